// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI traffic generator.
package axi_tg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StDone
  } tg_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B    = 3'b000;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Byte k of a run carries seed+k, wrapping modulo 256.
  function automatic logic [7:0] tg_pattern(input logic [7:0] seed, input logic [7:0] k);
    return seed + k;
  endfunction

endpackage

// File: rtl/axi_if.sv
// Minimal AXI4 bundle (16-bit address, 4-bit ID) between traffic generator and mesh.
interface axi_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [3:0]              awid;
  logic [15:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [3:0]              arid;
  logic [15:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [3:0]              rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_traffic_gen.sv
// Write-then-readback AXI4 burst generator with mismatch and latency counters.
module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter logic [3:0]  ID         = 4'h0,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  len,
  input  logic [7:0]  seed,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt,
  output logic [15:0] lat_cnt,
  axi_if.master       m_axi
);

  tg_state_e             state_q, state_d;
  logic [15:0]           base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            seed_q, seed_d;
  logic [7:0]            k_q, k_d;
  logic [7:0]            err_q, err_d;
  logic [15:0]           lat_q, lat_d;
  logic [1:0]            err_inc;
  logic [8:0]            err_sum;
  logic [DATA_WIDTH-1:0] pat;
  logic                  last_beat;
  logic                  aw_act, w_act, ar_act;

  assign pat       = tg_pattern(seed_q, k_q);
  assign last_beat = (k_q == len_q);
  assign aw_act    = (state_q == StAw);
  assign w_act     = (state_q == StW);
  assign ar_act    = (state_q == StAr);

  // Payloads are gated by their channel state so they read zero outside a request.
  assign m_axi.awvalid = aw_act;
  assign m_axi.awid    = aw_act ? ID : 4'h0;
  assign m_axi.awaddr  = aw_act ? base_q : 16'h0;
  assign m_axi.awlen   = aw_act ? len_q : 8'h0;
  assign m_axi.awsize  = SIZE_1B;
  assign m_axi.awburst = aw_act ? BURST_INCR : 2'b00;

  assign m_axi.wvalid  = w_act;
  assign m_axi.wdata   = w_act ? pat : '0;
  assign m_axi.wstrb   = w_act;
  assign m_axi.wlast   = w_act && last_beat;

  assign m_axi.bready  = (state_q == StB);

  assign m_axi.arvalid = ar_act;
  assign m_axi.arid    = ar_act ? ID : 4'h0;
  assign m_axi.araddr  = ar_act ? base_q : 16'h0;
  assign m_axi.arlen   = ar_act ? len_q : 8'h0;
  assign m_axi.arsize  = SIZE_1B;
  assign m_axi.arburst = ar_act ? BURST_INCR : 2'b00;

  assign m_axi.rready  = (state_q == StR);

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err_cnt = err_q;
  assign lat_cnt = lat_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    seed_d  = seed_q;
    k_d     = k_q;
    err_d   = err_q;
    lat_d   = lat_q;
    err_inc = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = len;
          seed_d  = seed;
          k_d     = 8'd0;
          err_d   = 8'd0;
          lat_d   = 16'd0;
          state_d = StAw;
        end
      end
      StAw: if (m_axi.awready) state_d = StW;
      StW: begin
        if (m_axi.wready) begin
          if (last_beat) begin
            k_d     = 8'd0;
            state_d = StB;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      StB: begin
        if (m_axi.bvalid) begin
          err_inc = {1'b0, (m_axi.bid != ID) || (m_axi.bresp != RESP_OKAY)};
          state_d = StAr;
        end
      end
      StAr: if (m_axi.arready) state_d = StR;
      StR: begin
        if (m_axi.rvalid) begin
          err_inc = 2'(m_axi.rdata != pat) + 2'(m_axi.rid != ID) + 2'(m_axi.rlast != last_beat);
          // The local beat count, not RLAST, decides when the burst is over.
          if (last_beat) begin
            k_d     = 8'd0;
            state_d = StDone;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q inside {StAw, StW, StB, StAr, StR}) begin
      lat_d = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
    end
    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    if (err_inc != 2'd0) begin
      err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      base_q  <= 16'h0;
      len_q   <= 8'h0;
      seed_q  <= 8'h0;
      k_q     <= 8'h0;
      err_q   <= 8'h0;
      lat_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      k_q     <= k_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench: behavioural AXI RAM slave plus a run-level model of the generator.
module tb_axi_traffic_gen;
  import axi_tg_pkg::*;

  localparam logic [3:0] TID = 4'h3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  len;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;
  logic [15:0] lat_cnt;

  axi_if #(.DATA_WIDTH(8)) bus ();

  axi_traffic_gen #(.ID(TID), .DATA_WIDTH(8)) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .lat_cnt   (lat_cnt),
    .m_axi     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Slave knobs
  int         aw_delay = 0;
  logic [8:0] corrupt_beat = 9'h1FF;
  logic [8:0] early_beat = 9'h1FF;
  logic [1:0] bresp_knob = 2'b00;

  // Slave state
  logic [7:0]  mem [0:65535];
  int          aw_cnt;
  logic        bvalid_r, rvalid_r, r_bubble;
  logic [15:0] waddr, raddr;
  logic [7:0]  rlen, rbeat, wk;
  int          r_hs_cnt;

  // Model state
  logic        model_run, model_done;
  logic [15:0] lat_model;
  logic [15:0] exp_base;
  logic [7:0]  exp_len, exp_seed;
  logic        aw_pend, w_pend;
  int          done_seen = 0;

  wire aw_hs = bus.awvalid && bus.awready;
  wire w_hs  = bus.wvalid && bus.wready;
  wire b_hs  = bus.bvalid && bus.bready;
  wire ar_hs = bus.arvalid && bus.arready;
  wire r_hs  = bus.rvalid && bus.rready;

  assign bus.awready = (aw_cnt >= aw_delay);
  assign bus.wready  = 1'b1;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = TID;
  assign bus.bresp   = bresp_knob;
  assign bus.arready = 1'b1;
  assign bus.rvalid  = rvalid_r;
  assign bus.rid     = TID;
  assign bus.rresp   = 2'b00;
  assign bus.rdata   = mem[raddr + {8'd0, rbeat}] ^ (({1'b0, rbeat} == corrupt_beat) ? 8'h5A : 8'h00);
  assign bus.rlast   = (rbeat == rlen) || ({1'b0, rbeat} == early_beat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt     <= 0;
      bvalid_r   <= 1'b0;
      rvalid_r   <= 1'b0;
      r_bubble   <= 1'b0;
      waddr      <= 16'h0;
      raddr      <= 16'h0;
      rlen       <= 8'h0;
      rbeat      <= 8'h0;
      wk         <= 8'h0;
      r_hs_cnt   <= 0;
      model_run  <= 1'b0;
      model_done <= 1'b0;
      lat_model  <= 16'h0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
    end else begin
      aw_pend <= bus.awvalid && !bus.awready;
      w_pend  <= bus.wvalid && !bus.wready;
      if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin
        aw_cnt <= 0;
        waddr  <= bus.awaddr;
        wk     <= 8'h0;
      end
      if (w_hs) begin
        mem[waddr] <= bus.wdata;
        waddr      <= waddr + 16'd1;
        wk         <= wk + 8'd1;
        if (bus.wlast) bvalid_r <= 1'b1;
      end
      if (b_hs) bvalid_r <= 1'b0;
      if (ar_hs) begin
        raddr    <= bus.araddr;
        rlen     <= bus.arlen;
        rbeat    <= 8'h0;
        r_bubble <= 1'b1;
      end
      if (r_bubble) begin
        r_bubble <= 1'b0;
        rvalid_r <= 1'b1;
      end
      if (r_hs) begin
        rbeat    <= rbeat + 8'd1;
        r_hs_cnt <= r_hs_cnt + 1;
        if (rbeat == rlen) rvalid_r <= 1'b0;
      end
      // Run model: latency spans the edges after start through the last R beat.
      model_done <= 1'b0;
      if (start && !model_run && !model_done) begin
        model_run <= 1'b1;
        lat_model <= 16'h0;
        exp_base  <= base_addr;
        exp_len   <= len;
        exp_seed  <= seed;
      end else if (model_run) begin
        lat_model <= lat_model + 16'd1;
        if (r_hs && rbeat == rlen) begin
          model_run  <= 1'b0;
          model_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, model_run || model_done);
      check("done", done, model_done);
      if (done) done_seen++;
      if (aw_pend) check("aw_hold", bus.awvalid, 1);
      if (w_pend) check("w_hold", bus.wvalid, 1);
      if (bus.awvalid) begin
        check("awaddr", bus.awaddr, exp_base);
        check("awlen", bus.awlen, exp_len);
        check("awsize", bus.awsize, 3'b000);
        check("awburst", bus.awburst, 2'b01);
        check("awid", bus.awid, TID);
      end
      if (bus.wvalid) begin
        check("wdata", bus.wdata, 8'(exp_seed + wk));
        check("wlast", bus.wlast, wk == exp_len);
        check("wstrb", bus.wstrb, 1);
      end
      if (bus.arvalid) begin
        check("araddr", bus.araddr, exp_base);
        check("arlen", bus.arlen, exp_len);
        check("arburst", bus.arburst, 2'b01);
        check("arid", bus.arid, TID);
      end
    end
  end

  task automatic run(input string nm, input logic [15:0] b, input logic [7:0] l,
                     input logic [7:0] s, input int awd, input logic [8:0] cb,
                     input logic [8:0] eb, input logic [1:0] br, input bit inj,
                     input logic [7:0] exp_err, input logic [15:0] exp_lat);
    int  r0, d0;
    bit  seen, fired;
    aw_delay     = awd;
    corrupt_beat = cb;
    early_beat   = eb;
    bresp_knob   = br;
    seen         = 0;
    fired        = 0;
    @(negedge clk);
    base_addr = b;
    len       = l;
    seed      = s;
    r0        = r_hs_cnt;
    d0        = done_seen;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inj && !fired && bus.wvalid && wk == 8'd1) begin
        start = 1'b1;
        fired = 1;
      end
      if (done) begin
        if (inj) start = 1'b1;
        seen = 1;
        break;
      end
    end
    check({nm, " finished"}, seen, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({nm, " err_cnt"}, err_cnt, exp_err);
    check({nm, " lat_cnt"}, lat_cnt, exp_lat);
    check({nm, " lat_model"}, lat_cnt, lat_model);
    check({nm, " done_once"}, done_seen - d0, 1);
    check({nm, " r_beats"}, r_hs_cnt - r0, int'(l) + 1);
    check({nm, " idle"}, busy, 0);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 16'h0;
    len       = 8'h0;
    seed      = 8'h0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err_cnt, 0);
    check("rst lat", lat_cnt, 0);
    check("rst valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("rst payload", {bus.awaddr, bus.awid, bus.awburst, bus.wdata, bus.wlast}, 0);
    rst_n = 1'b1;

    run("basic",   16'h0100, 8'd3, 8'hA0, 0, 9'h1FF, 9'h1FF, 2'b00, 0, 8'd0, 16'd12);
    check("mem A0", mem[16'h0100], 8'hA0);
    check("mem A3", mem[16'h0103], 8'hA3);
    run("aw_wait", 16'h0200, 8'd3, 8'h10, 5, 9'h1FF, 9'h1FF, 2'b00, 0, 8'd0, 16'd17);
    run("corrupt", 16'h0300, 8'd3, 8'h40, 0, 9'd2, 9'h1FF, 2'b00, 0, 8'd1, 16'd12);
    run("early",   16'h0300, 8'd3, 8'h40, 0, 9'd2, 9'd1, 2'b00, 0, 8'd2, 16'd12);
    run("bresp",   16'h0400, 8'd1, 8'h77, 0, 9'h1FF, 9'h1FF, 2'b10, 0, 8'd1, 16'd8);
    run("ign_st",  16'h0500, 8'd2, 8'h33, 0, 9'h1FF, 9'h1FF, 2'b00, 1, 8'd0, 16'd10);

    // Reset in the middle of a write burst.
    aw_delay     = 0;
    corrupt_beat = 9'h1FF;
    early_beat   = 9'h1FF;
    bresp_knob   = 2'b00;
    @(negedge clk);
    base_addr = 16'h0600;
    len       = 8'd7;
    seed      = 8'h01;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.wvalid && wk == 8'd1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_w reached", seen, 1);
    rst_n = 1'b0;
    #1;
    check("mid rst valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("mid rst busy", busy, 0);
    check("mid rst cnts", {err_cnt, lat_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 16'h0700, 8'd0, 8'h5C, 0, 9'h1FF, 9'h1FF, 2'b00, 0, 8'd0, 16'd6);

    run("long",    16'hF000, 8'd255, 8'h00, 0, 9'h1FF, 9'h1FF, 2'b00, 0, 8'd0, 16'd516);
    check("wrap FF", mem[16'hF0FF], 8'hFF);
    check("wrap 00", mem[16'hF000], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
